// File: rtl/gate_sequence_scheduler_if.sv
// Handshake bundle shared by the gate front end, the shared 2x2 complex multiplier and the
// result consumer. Matrices are [row][col][re=0/im=1] of 37-bit Q4.32 words.
interface gate_sequence_scheduler_if #(
    parameter int unsigned CNT_W = 7
);
    logic                       start;
    logic [0:1][0:1][0:1][36:0] gate_in;
    logic                       gate_valid;
    logic                       gate_last;
    logic                       gate_ready;
    logic [0:1][0:1][0:1][36:0] mul_mtx_a;
    logic [0:1][0:1][0:1][36:0] mul_mtx_b;
    logic                       mul_ready;
    logic [0:1][0:1][0:1][36:0] mul_mtx_r;
    logic                       mul_available;
    logic [0:1][0:1][0:1][36:0] result;
    logic                       result_valid;
    logic                       result_ready;
    logic [CNT_W-1:0]           gate_count;
    logic                       busy;
    logic                       overflow;

    modport slave (
        input  start, gate_in, gate_valid, gate_last, mul_mtx_r, mul_available, result_ready,
        output gate_ready, mul_mtx_a, mul_mtx_b, mul_ready, result, result_valid, gate_count,
               busy, overflow
    );

    modport master (
        output start, gate_in, gate_valid, gate_last, mul_mtx_r, mul_available, result_ready,
        input  gate_ready, mul_mtx_a, mul_mtx_b, mul_ready, result, result_valid, gate_count,
               busy, overflow
    );
endinterface

// File: rtl/gate_sequence_scheduler.sv
// Folds a stream of 2x2 complex gate matrices into one composite unitary (U <= G x U) by
// sequencing the shared multiplier; matrices pass through untouched, no arithmetic here.
module gate_sequence_scheduler #(
    parameter int unsigned        MAX_GATES = 64,
    parameter int unsigned        CNT_W     = $clog2(MAX_GATES + 1),
    parameter logic signed [36:0] ONE       = 37'sh1_0000_0000
) (
    input logic                      clk,
    input logic                      reset,
    gate_sequence_scheduler_if.slave bus
);
    typedef logic [0:1][0:1][0:1][36:0] mtx_t;
    typedef enum logic [2:0] {StIdle, StWaitGate, StIssue, StWaitMul, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_GATES);

    state_e           state_q;
    mtx_t             acc_q;
    mtx_t             gate_q;
    logic             last_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    mtx_t             identity;
    logic [CNT_W-1:0] count_inc;

    always_comb begin
        identity          = '0;
        identity[0][0][0] = ONE;
        identity[1][1][0] = ONE;
    end

    assign count_inc = count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            gate_q     <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        acc_q      <= identity;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        state_q    <= StWaitGate;
                    end
                end
                StWaitGate: begin
                    if (bus.gate_valid) begin
                        gate_q  <= bus.gate_in;
                        last_q  <= bus.gate_last;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.mul_available) state_q <= StWaitMul;
                end
                StWaitMul: begin
                    // The multiplier drops mul_available on entry; its return marks the result.
                    if (bus.mul_available) begin
                        acc_q   <= bus.mul_mtx_r;
                        count_q <= count_inc;
                        if (last_q) begin
                            state_q <= StDone;
                        end else if (count_inc == CntMax) begin
                            overflow_q <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            state_q <= StWaitGate;
                        end
                    end
                end
                StDone: begin
                    if (bus.result_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Operands come straight from registers so they hold across the multiplier's read window.
    assign bus.mul_mtx_a    = gate_q;
    assign bus.mul_mtx_b    = acc_q;
    assign bus.result       = acc_q;
    assign bus.gate_count   = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.gate_ready   = (state_q == StWaitGate);
    assign bus.mul_ready    = (state_q == StIssue) && bus.mul_available;
    assign bus.result_valid = (state_q == StDone);
    assign bus.busy         = (state_q != StIdle);
endmodule
